// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, column
// one-hot constants, default timing and scan-map helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  localparam logic [3:0] COL0 = 4'b0001;
  localparam logic [3:0] COL1 = 4'b0010;
  localparam logic [3:0] COL2 = 4'b0100;
  localparam logic [3:0] COL3 = 4'b1000;

  localparam logic [19:0] SCAN_CNT_DEF  = 20'd50000;
  localparam int          DEB_SCANS_DEF = 4;

  function automatic logic [3:0] col_onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    col_onehot = COL0;
      2'd1:    col_onehot = COL1;
      2'd2:    col_onehot = COL2;
      default: col_onehot = COL3;
    endcase
  endfunction

  function automatic logic [4:0] map_pop(input logic [15:0] m);
    logic [4:0] pop;
    pop = '0;
    for (int i = 0; i < 16; i++) pop = pop + 5'((m >> i) & 16'd1);
    return pop;
  endfunction

  // Index of the highest set bit; only meaningful when exactly one bit is set.
  function automatic logic [3:0] map_code(input logic [15:0] m);
    logic [3:0] code;
    code = '0;
    for (int i = 0; i < 16; i++)
      if (((m >> i) & 16'd1) != 16'd0) code = 4'(i);
    return code;
  endfunction

endpackage

// File: rtl/kp_row_sync.sv
// Two-flop synchronizer for the active-low keypad rows; resets to "no key".
module kp_row_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] sync_p0;
  logic [3:0] sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 4'b1111;
      sync_p1 <= 4'b1111;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, row sampling into a scan map,
// whole-scan debounce with ghost rejection, and press/release strobes.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter logic [19:0] SCAN_CNT  = SCAN_CNT_DEF,
  parameter int          DEB_SCANS = DEB_SCANS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic       key_release
);

  localparam int            CW      = $clog2(DEB_SCANS + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_SCANS);

  logic [3:0]    row_s;
  logic [19:0]   slot_cnt;
  logic [1:0]    col_idx;
  logic [15:0]   scan_map;
  logic [15:0]   row_bits;
  logic          sample;
  logic          scan_done;
  logic [4:0]    pop;
  logic [3:0]    code;
  logic          is_none;
  logic          is_single;
  kp_state_t     state, state_nxt;
  logic [CW-1:0] deb_cnt, deb_nxt, deb_inc;
  logic [CW-1:0] rel_cnt, rel_nxt, rel_inc;
  logic [3:0]    cand, cand_nxt, code_nxt;
  logic          valid_nxt, down_nxt, release_nxt;

  kp_row_sync u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_n),
    .q     (row_s)
  );

  // Sample at the end of each slot so the rows have settled after the column switch.
  assign sample   = (slot_cnt == SCAN_CNT);
  assign row_bits = {3'b000, ~row_s[3], 3'b000, ~row_s[2],
                     3'b000, ~row_s[1], 3'b000, ~row_s[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt  <= '0;
      col_idx   <= '0;
      col_n     <= 4'b1111;
      scan_map  <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= sample && (col_idx == 2'd3);
      if (sample) begin
        slot_cnt <= '0;
        col_idx  <= col_idx + 2'd1;
        col_n    <= ~col_onehot(col_idx + 2'd1);
        scan_map <= scan_map | (row_bits << col_idx);
      end else begin
        slot_cnt <= slot_cnt + 20'd1;
        col_n    <= ~col_onehot(col_idx);
        if (scan_done) scan_map <= '0;
      end
    end
  end

  assign pop       = map_pop(scan_map);
  assign code      = map_code(scan_map);
  assign is_none   = (pop == 5'd0);
  assign is_single = (pop == 5'd1);
  assign deb_inc   = (deb_cnt == DEB_MAX) ? deb_cnt : deb_cnt + 1'b1;
  assign rel_inc   = (rel_cnt == DEB_MAX) ? rel_cnt : rel_cnt + 1'b1;

  always_comb begin
    state_nxt   = state;
    deb_nxt     = deb_cnt;
    rel_nxt     = rel_cnt;
    cand_nxt    = cand;
    code_nxt    = key_code;
    down_nxt    = key_down;
    valid_nxt   = 1'b0;
    release_nxt = 1'b0;
    if (scan_done) begin
      case (state)
        IDLE: begin
          if (is_single) begin
            state_nxt = DEBOUNCE;
            cand_nxt  = code;
            deb_nxt   = CW'(1);
          end
        end
        DEBOUNCE: begin
          if (is_single && (code == cand)) begin
            deb_nxt = deb_inc;
            if (deb_inc == DEB_MAX) begin
              state_nxt = PRESSED;
              code_nxt  = cand;
              valid_nxt = 1'b1;
              down_nxt  = 1'b1;
            end
          end else begin
            state_nxt = IDLE;
            deb_nxt   = '0;
          end
        end
        PRESSED: begin
          // Extra keys while one is held never change the accepted code.
          if (is_none) begin
            state_nxt = RELEASE;
            rel_nxt   = CW'(1);
          end
        end
        RELEASE: begin
          if (is_none) begin
            rel_nxt = rel_inc;
            if (rel_inc == DEB_MAX) begin
              state_nxt   = IDLE;
              rel_nxt     = '0;
              deb_nxt     = '0;
              down_nxt    = 1'b0;
              release_nxt = 1'b1;
            end
          end else begin
            state_nxt = PRESSED;
            rel_nxt   = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      deb_cnt     <= '0;
      rel_cnt     <= '0;
      cand        <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_down    <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_nxt;
      deb_cnt     <= deb_nxt;
      rel_cnt     <= rel_nxt;
      cand        <= cand_nxt;
      key_code    <= code_nxt;
      key_valid   <= valid_nxt;
      key_down    <= down_nxt;
      key_release <= release_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: an ideal keypad answers the column drive, and a
// per-scan behavioural model predicts every output on every cycle.
module tb_keypad_scan;

  localparam int DEB = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic        key_release;
  logic [15:0] keys = 16'h0000;

  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  int rcnt = 0;

  keypad_scan #(.SCAN_CNT(20'd3), .DEB_SCANS(DEB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_n       (row_n),
    .col_n       (col_n),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_down    (key_down),
    .key_release (key_release)
  );

  always #5 clk = ~clk;

  // Ideal keypad: a held key pulls its row low while its column is driven.
  always_comb begin
    row_n[0] = ~|(keys[3:0]   & ~col_n);
    row_n[1] = ~|(keys[7:4]   & ~col_n);
    row_n[2] = ~|(keys[11:8]  & ~col_n);
    row_n[3] = ~|(keys[15:12] & ~col_n);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: cycle count since reset release decides the column and the scan
  // boundaries; each completed scan is judged from the keys held during it.
  int          cyc;
  logic [15:0] sk;
  bit          held, ev, er;
  int          run, rel, cand, code;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; sk = '0; held = 0; ev = 0; er = 0;
      run = 0; rel = 0; cand = 0; code = 0;
    end else begin
      int n, c;
      cyc++;
      ev = 0;
      er = 0;
      if (cyc % 16 == 8) sk = keys;
      if (cyc % 16 == 1 && cyc > 1) begin
        n = $countones(sk);
        c = 0;
        for (int i = 0; i < 16; i++)
          if (((sk >> i) & 16'd1) != 16'd0) c = i;
        if (!held) begin
          if (n == 1 && run > 0 && c == cand) run++;
          else if (n == 1 && run == 0) begin run = 1; cand = c; end
          else run = 0;
          if (run == DEB) begin held = 1; code = cand; ev = 1; run = 0; end
        end else if (n == 0) begin
          rel++;
          if (rel == DEB) begin held = 0; er = 1; rel = 0; end
        end else begin
          rel = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] ecol;
    ecol = 4'b1111;
    if (rst_n && cyc > 0) ecol = ~(4'b0001 << ((cyc / 4) % 4));
    chk("col_n", 16'(col_n), 16'(ecol));
    chk("key_valid", 16'(key_valid), 16'(ev));
    chk("key_release", 16'(key_release), 16'(er));
    chk("key_down", 16'(key_down), 16'(held));
    chk("key_code", 16'(key_code), 16'(code));
    if (key_valid === 1'b1) vcnt++;
    if (key_release === 1'b1) rcnt++;
  end

  task automatic scans(input logic [15:0] m, input int n);
    keys = m;
    repeat (16 * n) @(negedge clk);
  endtask

  task automatic release_reset();
    keys = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_now(input string tag);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_col_n"}, 16'(col_n), 16'hF);
    chk({tag, "_key_down"}, 16'(key_down), 16'h0);
    chk({tag, "_key_code"}, 16'(key_code), 16'h0);
    chk({tag, "_key_valid"}, 16'(key_valid), 16'h0);
    chk({tag, "_key_release"}, 16'(key_release), 16'h0);
  endtask

  localparam logic [15:0] K0  = 16'h0001;
  localparam logic [15:0] K9  = 16'h0200;
  localparam logic [15:0] K56 = 16'h0060;

  initial begin
    // 1: reset, then idle with column rotation
    repeat (3) @(negedge clk);
    chk("rst_col_n", 16'(col_n), 16'hF);
    release_reset();
    chk("col0", 16'(col_n), 16'b1110);
    repeat (4) @(negedge clk);
    chk("col1", 16'(col_n), 16'b1101);
    repeat (4) @(negedge clk);
    chk("col2", 16'(col_n), 16'b1011);
    repeat (4) @(negedge clk);
    chk("col3", 16'(col_n), 16'b0111);
    repeat (4) @(negedge clk);
    scans('0, 12);
    chk("t1_valids", 16'(vcnt), 16'd0);
    chk("t1_down", 16'(key_down), 16'd0);

    // 2: key 9 held for 4 scans, then released
    scans(K9, 4);
    chk("t2_valids", 16'(vcnt), 16'd1);
    chk("t2_code", 16'(key_code), 16'd9);
    chk("t2_down", 16'(key_down), 16'd1);
    scans('0, 4);
    chk("t2_releases", 16'(rcnt), 16'd1);
    chk("t2_down_off", 16'(key_down), 16'd0);
    chk("t2_code_hold", 16'(key_code), 16'd9);

    // 3: short press rejected, then clean press of key 0
    scans(K9, 2);
    scans('0, 1);
    chk("t3_short", 16'(vcnt), 16'd1);
    scans(K0, 4);
    chk("t3_valids", 16'(vcnt), 16'd2);
    chk("t3_code", 16'(key_code), 16'd0);
    scans('0, 4);
    chk("t3_releases", 16'(rcnt), 16'd2);

    // 4: two keys together never accepted
    scans(K56, 10);
    chk("t4_multi", 16'(vcnt), 16'd2);
    scans('0, 1);

    // 5: bounce during release only produces one release at the end
    scans(K9, 3);
    scans('0, 1);
    chk("t5_valids", 16'(vcnt), 16'd3);
    scans(K9, 1);
    scans('0, 2);
    chk("t5_down_held", 16'(key_down), 16'd1);
    chk("t5_no_rel", 16'(rcnt), 16'd2);
    scans('0, 2);
    chk("t5_releases", 16'(rcnt), 16'd3);
    chk("t5_down_off", 16'(key_down), 16'd0);
    chk("t5_valids2", 16'(vcnt), 16'd3);

    // 6: async reset mid-debounce and while pressed
    scans(K9, 2);
    keys = K9;
    repeat (7) @(negedge clk);
    reset_now("t6a");
    release_reset();
    scans(K9, 4);
    chk("t6_valids", 16'(vcnt), 16'd4);
    chk("t6_down", 16'(key_down), 16'd1);
    keys = K9;
    repeat (5) @(negedge clk);
    reset_now("t6b");
    release_reset();
    scans('0, 4);
    chk("t6_no_rel", 16'(rcnt), 16'd3);
    chk("t6_valids2", 16'(vcnt), 16'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
